edc_secded_unit: RTL and testbench
==================================

Name: edc_secded_unit

Overview:
- SECDED error detection/correction unit for a 32-bit data path with an 8-bit ECC memory. It sits between main memory, ECC memory and the data multiplexor.
- Write mode: produces the 8-bit check code to store in ECC memory.
- Read mode: produces the syndrome of the incoming data/ECC pair, corrects any single-bit data error, and flags uncorrectable errors.
- Combinational generate/decode path, followed by one output register stage.

Parameters:
- none. Widths are fixed: DATA_W=32 and ECC_W=8, defined in the shared package.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_write_enabled  in  1  1=write (generate ECC), 0=read (check and correct).
- i_data  in  32  data word from the multiplexor (write) or main memory (read).
- i_ecc  in  8  stored check code from ECC memory; ignored in write mode.
- o_ecc_syndrome  out  8  write: check code for i_data; read: computed code XOR i_ecc.
- o_data  out  32  corrected data; equals i_data in write mode.
- o_error_detected  out  1  read-mode syndrome nonzero.
- o_uncorrected_error  out  1  read-mode error that cannot be corrected.

Behaviour:
- Check matrix: data bit j has a column COL[j], the j-th smallest 8-bit value of Hamming weight 3, in ascending order.
  - COL[0..31] = 07,0B,0D,0E,13,15,16,19,1A,1C,23,25,26,29,2A,2C,31,32,34,38,43,45,46,49,4A,4C,51,52,54,58,61,62 (hex).
  - ecc bit k = XOR over j of (i_data[j] AND COL[j][k]).
  - ecc[7] is therefore always 0 for generated codes.
- Write (i_write_enabled=1):
  - syndrome = computed ecc.
  - o_data = i_data.
  - Both flags 0.
- Read (i_write_enabled=0): S = computed ecc XOR i_ecc.
  - S==0: no error. o_data=i_data, flags 0.
  - S equals COL[j]: single data-bit error. o_data = i_data with bit j inverted. detected=1, uncorrected=0.
  - S has weight 1: single check-bit error. o_data=i_data, detected=1, uncorrected=0.
  - Any other nonzero S (even weight, or odd weight not in the table): o_data=i_data unmodified, detected=1, uncorrected=1.
- Timing: all four outputs are registered. Latency is one cycle; a new input is accepted every cycle with no handshake.
- Reset: asynchronous. All outputs go to 0 while i_reset=1; registers capture normally from the first rising edge after release.
- i_write_enabled is sampled with the data on the same edge. A mode change between cycles has no side effects, because there is no internal state beyond the output registers.

Decomposition:
- Package edc_pkg holds: DATA_W, ECC_W, the COL[0:31] constant array, and a function computing ecc from data.
- One sub-module, edc_syndrome_decode, is combinational: it takes (syndrome, data) and returns (corrected data, detected, uncorrected).
- The top level edc_secded_unit contains: the generator XOR tree, the write/read muxing, the decoder instance, and the output registers.

Test Plan:
- Write mode, i_data=E3A02001 -> o_ecc_syndrome=7F, o_data=E3A02001, both flags 0, one cycle later.
- Read, i_data=E3A02001, i_ecc=7E (ecc bit 0 flipped) -> syndrome=01, o_data=E3A02001, detected=1, uncorrected=0.
- Read, i_data=E3A02000 (data bit 0 flipped), i_ecc=7F -> syndrome=07, o_data=E3A02001, detected=1, uncorrected=0.
  - Sweep all 32 data bits: each flip yields syndrome=COL[j] and the word is fully corrected.
- Read, i_data=E3A02003 (bit 1 flipped), i_ecc=7E -> syndrome=0A (weight 2), o_data=E3A02003, detected=1, uncorrected=1.
- Read, i_data=E3A02001, i_ecc=7F -> syndrome=00, both flags 0; then assert i_reset mid-stream -> all outputs immediately 0 until the first edge after release.

Source files
------------

// File: rtl/edc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edc_pkg
// Description : Shared widths, SECDED check-matrix columns and the check-code
//               generator function for the 32-bit / 8-bit EDC unit.
//               COL[j] is the j-th smallest 8-bit value of Hamming weight 3.
//               Bit 7 is never set in any column, so generated codes always
//               have bit 7 cleared.
// Revision    : 1.0 - initial release
// ============================================================================
package edc_pkg;

    localparam int DATA_W = 32;
    localparam int ECC_W  = 8;

    localparam logic [ECC_W-1:0] COL [0:DATA_W-1] = '{
        8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
        8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
        8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
        8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62
    };

    // Each set data bit contributes its column to the code. This unrolls into
    // one XOR tree per check bit.
    function automatic logic [ECC_W-1:0] compute_ecc(input logic [DATA_W-1:0] data);
        logic [ECC_W-1:0] ecc;
        ecc = '0;
        for (int j = 0; j < DATA_W; j++) begin
            if (data[j]) begin
                ecc = ecc ^ COL[j];
            end
        end
        return ecc;
    endfunction

endpackage : edc_pkg
`default_nettype wire

// File: rtl/edc_syndrome_decode.sv
`default_nettype none
// ============================================================================
// Module      : edc_syndrome_decode
// Description : Combinational SECDED syndrome decoder.
//               A syndrome matching a data column flips that data bit; a
//               weight-1 syndrome is a check-bit error (data untouched);
//               any other nonzero syndrome is uncorrectable.
// Ports       : i_syndrome          - computed code XOR stored code
//               i_data              - data word as read
//               o_data              - corrected data word
//               o_error_detected    - syndrome nonzero
//               o_uncorrected_error - nonzero syndrome that cannot be fixed
// Revision    : 1.0 - initial release
// ============================================================================
module edc_syndrome_decode
    import edc_pkg::*;
(
    input  logic [ECC_W-1:0]  i_syndrome,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_error_detected,
    output logic              o_uncorrected_error
);

    logic [DATA_W-1:0] w_flip;
    logic              w_data_hit;
    logic              w_check_hit;

    // Columns are unique, so at most one bit of w_flip can be set.
    genvar j;
    generate
        for (j = 0; j < DATA_W; j++) begin : g_col_match
            assign w_flip[j] = (i_syndrome == COL[j]);
        end
    endgenerate

    assign w_data_hit  = |w_flip;
    // Power-of-two test: exactly one bit set.
    assign w_check_hit = (i_syndrome != '0) &&
                         ((i_syndrome & (i_syndrome - ECC_W'(1))) == '0);

    assign o_data              = i_data ^ w_flip;
    assign o_error_detected    = (i_syndrome != '0);
    assign o_uncorrected_error = o_error_detected && !w_data_hit && !w_check_hit;

endmodule : edc_syndrome_decode
`default_nettype wire

// File: rtl/edc_secded_unit.sv
`default_nettype none
// ============================================================================
// Module      : edc_secded_unit
// Description : SECDED error detection/correction unit, 32-bit data with an
//               8-bit check code. Write mode emits the check code to store;
//               read mode emits the syndrome, corrects single data-bit errors
//               and flags uncorrectable errors. One output register stage,
//               one new input per cycle.
// Ports       : i_clk               - clock, rising edge
//               i_reset             - asynchronous active-high reset
//               i_write_enabled     - 1 = generate code, 0 = check/correct
//               i_data              - data word
//               i_ecc               - stored check code (read mode only)
//               o_ecc_syndrome      - write: check code; read: syndrome
//               o_data              - corrected data (write: i_data)
//               o_error_detected    - read-mode nonzero syndrome
//               o_uncorrected_error - read-mode uncorrectable error
// Revision    : 1.0 - initial release
// ============================================================================
module edc_secded_unit
    import edc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_write_enabled,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ECC_W-1:0]  i_ecc,
    output logic [ECC_W-1:0]  o_ecc_syndrome,
    output logic [DATA_W-1:0] o_data,
    output logic              o_error_detected,
    output logic              o_uncorrected_error
);

    logic [ECC_W-1:0]  w_gen_ecc;
    logic [ECC_W-1:0]  w_read_syn;
    logic [DATA_W-1:0] w_dec_data;
    logic              w_dec_detected;
    logic              w_dec_uncorrected;

    logic [ECC_W-1:0]  w_nxt_syn;
    logic [DATA_W-1:0] w_nxt_data;
    logic              w_nxt_detected;
    logic              w_nxt_uncorrected;

    logic [ECC_W-1:0]  r_syn;
    logic [DATA_W-1:0] r_data;
    logic              r_detected;
    logic              r_uncorrected;

    assign w_gen_ecc  = compute_ecc(i_data);
    assign w_read_syn = w_gen_ecc ^ i_ecc;

    edc_syndrome_decode u_decode (
        .i_syndrome          (w_read_syn),
        .i_data              (i_data),
        .o_data              (w_dec_data),
        .o_error_detected    (w_dec_detected),
        .o_uncorrected_error (w_dec_uncorrected)
    );

    // Write mode bypasses the decoder entirely: i_ecc is ignored.
    always_comb begin
        w_nxt_syn         = w_gen_ecc;
        w_nxt_data        = i_data;
        w_nxt_detected    = 1'b0;
        w_nxt_uncorrected = 1'b0;
        if (!i_write_enabled) begin
            w_nxt_syn         = w_read_syn;
            w_nxt_data        = w_dec_data;
            w_nxt_detected    = w_dec_detected;
            w_nxt_uncorrected = w_dec_uncorrected;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_syn         <= '0;
            r_data        <= '0;
            r_detected    <= 1'b0;
            r_uncorrected <= 1'b0;
        end else begin
            r_syn         <= w_nxt_syn;
            r_data        <= w_nxt_data;
            r_detected    <= w_nxt_detected;
            r_uncorrected <= w_nxt_uncorrected;
        end
    end

    assign o_ecc_syndrome      = r_syn;
    assign o_data              = r_data;
    assign o_error_detected    = r_detected;
    assign o_uncorrected_error = r_uncorrected;

endmodule : edc_secded_unit
`default_nettype wire

// File: tb/tb_edc_secded_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_edc_secded_unit
// Description : Self-checking bench for edc_secded_unit. A reference model
//               derives the check matrix by enumerating weight-3 byte values
//               and decodes syndromes by table search.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edc_secded_unit;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] din;
    logic [7:0]  ein;
    logic [7:0]  o_syn;
    logic [31:0] o_dat;
    logic        o_det;
    logic        o_unc;

    int n_cmp;
    int n_err;

    logic [7:0] col_m [32];

    edc_secded_unit dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_write_enabled     (we),
        .i_data              (din),
        .i_ecc               (ein),
        .o_ecc_syndrome      (o_syn),
        .o_data              (o_dat),
        .o_error_detected    (o_det),
        .o_uncorrected_error (o_unc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Check matrix: ascending byte values with exactly three bits set.
    task automatic build_cols();
        int n;
        n = 0;
        for (int v = 0; v < 256; v++) begin
            if ($countones(v) == 3 && n < 32) begin
                col_m[n] = v[7:0];
                n++;
            end
        end
    endtask

    function automatic logic [7:0] ref_code(input logic [31:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int j = 0; j < 32; j++) begin
            if (d[j]) c = c ^ col_m[j];
        end
        return c;
    endfunction

    task automatic ref_model(input logic w, input logic [31:0] d, input logic [7:0] e,
                             output logic [7:0] s, output logic [31:0] od,
                             output logic det, output logic unc);
        int hit;
        od  = d;
        det = 1'b0;
        unc = 1'b0;
        if (w) begin
            s = ref_code(d);
        end else begin
            s   = ref_code(d) ^ e;
            hit = -1;
            for (int j = 0; j < 32; j++) begin
                if (col_m[j] == s) hit = j;
            end
            if (s != 8'h00) begin
                det = 1'b1;
                if (hit >= 0) od[hit] = ~d[hit];
                else if ($countones(s) != 1) unc = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] es, input logic [31:0] ed,
                         input logic edet, input logic eunc);
        n_cmp++;
        assert (o_syn === es) else begin
            n_err++;
            $error("FAIL %s syndrome observed=%h expected=%h", tag, o_syn, es);
        end
        n_cmp++;
        assert (o_dat === ed) else begin
            n_err++;
            $error("FAIL %s data observed=%h expected=%h", tag, o_dat, ed);
        end
        n_cmp++;
        assert (o_det === edet) else begin
            n_err++;
            $error("FAIL %s detected observed=%b expected=%b", tag, o_det, edet);
        end
        n_cmp++;
        assert (o_unc === eunc) else begin
            n_err++;
            $error("FAIL %s uncorrected observed=%b expected=%b", tag, o_unc, eunc);
        end
    endtask

    // Apply one input on the falling edge, check the registered result just
    // after the next rising edge.
    task automatic step(input string tag, input logic w, input logic [31:0] d,
                        input logic [7:0] e);
        logic [7:0]  s;
        logic [31:0] od;
        logic        det;
        logic        unc;
        @(negedge clk);
        we  = w;
        din = d;
        ein = e;
        @(posedge clk);
        #1;
        ref_model(w, d, e, s, od, det, unc);
        check(tag, s, od, det, unc);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  e;
        logic [7:0]  s;
        logic [31:0] od;
        logic        det;
        logic        unc;
        int          kind;

        n_cmp = 0;
        n_err = 0;
        build_cols();

        rst = 1'b1;
        we  = 1'b1;
        din = 32'hFFFF_FFFF;
        ein = 8'hFF;
        @(posedge clk);
        #1;
        check("reset", 8'h00, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors with hand-derived expectations.
        step("wr_e3a", 1'b1, 32'hE3A0_2001, 8'h00);
        check("wr_e3a_const", 8'h7F, 32'hE3A0_2001, 1'b0, 1'b0);
        step("rd_chk0", 1'b0, 32'hE3A0_2001, 8'h7E);
        check("rd_chk0_const", 8'h01, 32'hE3A0_2001, 1'b1, 1'b0);
        step("rd_dat0", 1'b0, 32'hE3A0_2000, 8'h7F);
        check("rd_dat0_const", 8'h07, 32'hE3A0_2001, 1'b1, 1'b0);
        step("rd_dbl", 1'b0, 32'hE3A0_2003, 8'h7E);
        check("rd_dbl_const", 8'h0A, 32'hE3A0_2003, 1'b1, 1'b1);
        step("wr_ignores_ecc", 1'b1, 32'hE3A0_2001, 8'hA5);
        check("wr_ignores_ecc_const", 8'h7F, 32'hE3A0_2001, 1'b0, 1'b0);

        // Single data-bit sweep around a known-good word.
        for (int j = 0; j < 32; j++) begin
            d = 32'hE3A0_2001;
            d[j] = ~d[j];
            step("sweep", 1'b0, d, 8'h7F);
            check("sweep_fix", col_m[j], 32'hE3A0_2001, 1'b1, 1'b0);
        end

        // Single check-bit sweep.
        for (int k = 0; k < 8; k++) begin
            e = 8'h7F;
            e[k] = ~e[k];
            step("chk_sweep", 1'b0, 32'hE3A0_2001, e);
        end

        // Randomized mix of error classes, including back-to-back mode swaps.
        for (int i = 0; i < 400; i++) begin
            d    = $urandom;
            kind = $urandom_range(0, 5);
            e    = ref_code(d);
            case (kind)
                0: step("rnd_wr", 1'b1, d, 8'($urandom));
                1: step("rnd_clean", 1'b0, d, e);
                2: begin
                    d[$urandom_range(0, 31)] ^= 1'b1;
                    step("rnd_sbe_data", 1'b0, d, e);
                end
                3: begin
                    e[$urandom_range(0, 7)] ^= 1'b1;
                    step("rnd_sbe_chk", 1'b0, d, e);
                end
                4: begin
                    int a;
                    int b;
                    a = $urandom_range(0, 39);
                    b = (a + $urandom_range(1, 39)) % 40;
                    if (a < 32) d[a] ^= 1'b1; else e[a-32] ^= 1'b1;
                    if (b < 32) d[b] ^= 1'b1; else e[b-32] ^= 1'b1;
                    step("rnd_dbe", 1'b0, d, e);
                end
                default: step("rnd_any", 1'b0, d, 8'($urandom));
            endcase
        end

        // Clean read, then asynchronous reset mid-stream.
        step("rd_clean", 1'b0, 32'hE3A0_2001, 8'h7F);
        check("rd_clean_const", 8'h00, 32'hE3A0_2001, 1'b0, 1'b0);
        step("pre_rst", 1'b1, 32'hE3A0_2001, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 8'h00, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold", 8'h00, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_released", 8'h00, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        ref_model(we, din, ein, s, od, det, unc);
        check("post_rst", s, od, det, unc);
        check("post_rst_const", 8'h7F, 32'hE3A0_2001, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_edc_secded_unit
`default_nettype wire
